// File: rtl/mul_hilo_ctrl.sv
// HI/LO register file and multi-cycle sequencer for the EX-stage multiplier.
// Holds latched operands on the external multiplier for MUL_LAT cycles, then captures the product.
module mul_hilo_ctrl #(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic        clk_i,
  input  logic        reset,
  input  logic        op_valid_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] rs_val_i,
  input  logic [31:0] rt_val_i,
  input  logic        flush_i,
  output logic        mul_ena_o,
  output logic        mul_sign_o,
  output logic [31:0] mul_a_o,
  output logic [31:0] mul_b_o,
  input  logic [31:0] mul_hi_i,
  input  logic [31:0] mul_lo_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        busy_o,
  output logic        stall_o
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MTHI  = 3'b010;
  localparam logic [2:0] OP_MTLO  = 3'b011;
  localparam logic [2:0] OP_MFHI  = 3'b100;
  localparam logic [2:0] OP_MFLO  = 3'b101;

  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

  typedef enum logic {IDLE, MUL} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] hi_q, lo_q, rdata_q, mul_a_q, mul_b_q;
  logic        mul_sign_q, mul_ena_q, rdata_valid_q, busy_q;

  // A zero operand makes the product trivially zero, so it is written directly
  // without occupying the multiplier.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      hi_q          <= 32'd0;
      lo_q          <= 32'd0;
      rdata_q       <= 32'd0;
      mul_a_q       <= 32'd0;
      mul_b_q       <= 32'd0;
      mul_sign_q    <= 1'b0;
      mul_ena_q     <= 1'b0;
      rdata_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      rdata_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (op_valid_i && !flush_i) begin
            case (op_i)
              OP_MULT, OP_MULTU: begin
                if ((rs_val_i != 32'd0) && (rt_val_i != 32'd0)) begin
                  mul_a_q    <= rs_val_i;
                  mul_b_q    <= rt_val_i;
                  mul_sign_q <= ~op_i[0];
                  cnt_q      <= CNT_INIT;
                  state_q    <= MUL;
                  busy_q     <= 1'b1;
                  mul_ena_q  <= 1'b1;
                end else begin
                  hi_q <= 32'd0;
                  lo_q <= 32'd0;
                end
              end
              OP_MTHI: hi_q <= rs_val_i;
              OP_MTLO: lo_q <= rs_val_i;
              OP_MFHI: begin
                rdata_q       <= hi_q;
                rdata_valid_q <= 1'b1;
              end
              OP_MFLO: begin
                rdata_q       <= lo_q;
                rdata_valid_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          // A flush abandons the product even on the capture cycle.
          if (flush_i) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            busy_q    <= 1'b0;
            mul_ena_q <= 1'b0;
          end else if (cnt_q == 4'd0) begin
            hi_q      <= mul_hi_i;
            lo_q      <= mul_lo_i;
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            mul_ena_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Any real HI/LO op must wait for the multiply; no-op codes pass freely.
  assign stall_o = op_valid_i & busy_q & (op_i <= OP_MFLO);

  assign mul_ena_o     = mul_ena_q;
  assign mul_sign_o    = mul_sign_q;
  assign mul_a_o       = mul_a_q;
  assign mul_b_o       = mul_b_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rdata_valid_q;
  assign busy_o        = busy_q;

endmodule
